not_pipe: RTL and testbench

//  Parametrised, pipelined, multi-bit successor to the single-bit NOT gate.

---
 rtl/not_pipe_pkg.sv | 26 ++
 rtl/not_pipe_stage.sv | 30 +++
 rtl/not_pipe.sv | 83 ++++++++
 tb/tb_not_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/not_pipe_pkg.sv
// Shared definitions for not_pipe: operation mode encodings and the per-bit operation.
package not_pipe_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_NOT  = 2'b00;
  localparam mode_t MODE_PASS = 2'b01;
  localparam mode_t MODE_MASK = 2'b10;
  localparam mode_t MODE_RSVD = 2'b11;

  // Per-bit operation so the top can apply it across any WIDTH.
  function automatic logic op_apply(input logic a, input mode_t mode, input logic mask);
    logic r;
    case (mode)
      MODE_PASS: r = a;
      MODE_MASK: r = a ^ mask;
      default:   r = ~a;  // NOT, and reserved mode behaves as NOT
    endcase
    return r;
  endfunction

  function automatic logic op_err(input mode_t mode);
    return mode == MODE_RSVD;
  endfunction

endpackage

// File: rtl/not_pipe_stage.sv
// One elastic valid/ready pipeline register holding an opaque payload word.
module not_pipe_stage #(
  parameter int unsigned PW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [PW-1:0] up_payload,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [PW-1:0] dn_payload
);

  assign up_ready = ~dn_valid | dn_ready;

  // Payload only loads on a transfer, so it holds its last value when the stage empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid   <= 1'b0;
      dn_payload <= '0;
    end else if (up_valid && up_ready) begin
      dn_valid   <= 1'b1;
      dn_payload <= up_payload;
    end else if (dn_ready) begin
      dn_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/not_pipe.sv
// Pipelined multi-bit NOT/PASS/MASK with elastic stages and an output transfer counter.
// Optional NOT_PIPE_PARITY_EN adds out_par, the registered even parity of the result.
module not_pipe
  import not_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] xfer_cnt
`ifdef NOT_PIPE_PARITY_EN
  ,
  output logic             out_par
`endif
);

`ifdef NOT_PIPE_PARITY_EN
  localparam int unsigned PW = WIDTH + 2;
`else
  localparam int unsigned PW = WIDTH + 1;
`endif

  logic [WIDTH-1:0] result;
  logic             vld [STAGES+1];
  logic             rdy [STAGES+1];
  logic [PW-1:0]    pay [STAGES+1];

  always_comb begin
    result = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      result[i] = op_apply(in_data[i], in_mode, in_mask[i]);
    end
  end

`ifdef NOT_PIPE_PARITY_EN
  assign pay[0] = {^result, op_err(in_mode), result};
  assign out_par = pay[STAGES][WIDTH+1];
`else
  assign pay[0] = {op_err(in_mode), result};
`endif

  assign vld[0]      = in_valid;
  assign in_ready    = rdy[0];
  assign rdy[STAGES] = out_ready;
  assign out_valid   = vld[STAGES];
  assign out_data    = pay[STAGES][WIDTH-1:0];
  assign out_err     = pay[STAGES][WIDTH];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    not_pipe_stage #(
      .PW(PW)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .up_valid  (vld[k]),
      .up_ready  (rdy[k]),
      .up_payload(pay[k]),
      .dn_valid  (vld[k+1]),
      .dn_ready  (rdy[k+1]),
      .dn_payload(pay[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_not_pipe.sv
// Self-checking bench for not_pipe: scoreboard model plus directed latency/mode/backpressure/reset steps.
module tb_not_pipe;

  localparam int unsigned S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic [7:0] in_data, in_mask;
  logic [1:0] in_mode;

  logic       in_ready, out_valid, out_err;
  logic [7:0] out_data, xfer_cnt;
  logic       w_in_ready, w_out_valid, w_out_err;
  logic [7:0] w_out_data;
  logic [1:0] w_cnt;
`ifdef NOT_PIPE_PARITY_EN
  logic       out_par, w_out_par;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } item_t;

  item_t       q[$];
  int unsigned model_cnt;
  int          checks = 0;
  int          failures = 0;
  logic        last_acc;

  always #5 clk = ~clk;

  not_pipe #(.WIDTH(8), .STAGES(S), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .xfer_cnt(xfer_cnt)
`ifdef NOT_PIPE_PARITY_EN
    , .out_par(out_par)
`endif
  );

  // Second instance with a 2-bit counter to exercise wrap-around on the same traffic.
  not_pipe #(.WIDTH(8), .STAGES(S), .CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_data(in_data), .in_mode(in_mode), .in_mask(in_mask),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
    .out_err(w_out_err), .xfer_cnt(w_cnt)
`ifdef NOT_PIPE_PARITY_EN
    , .out_par(w_out_par)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic item_t model_op(input logic [7:0] a, input logic [1:0] m,
                                     input logic [7:0] k);
    item_t r;
    r.e = (m == 2'b11);
    if (m == 2'b01)      r.d = a;
    else if (m == 2'b10) r.d = a ^ k;
    else                 r.d = 8'hFF - a;
    return r;
  endfunction

  task automatic check_outputs();
    if (q.size() == 0) begin
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_valid_w", w_out_valid, 1'b0);
    end
    if (out_valid === 1'b1) begin
      chk("out_has_word", (q.size() != 0), 1'b1);
      if (q.size() != 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_err", out_err, q[0].e);
`ifdef NOT_PIPE_PARITY_EN
        chk("out_par", out_par, ^q[0].d);
`endif
      end
    end
    if (w_out_valid === 1'b1 && q.size() != 0) begin
      chk("out_data_w", w_out_data, q[0].d);
      chk("out_err_w", w_out_err, q[0].e);
    end
    chk("in_ready", in_ready, ((q.size() < S) || out_ready));
    chk("in_ready_w", w_in_ready, ((q.size() < S) || out_ready));
    chk("xfer_cnt", xfer_cnt, 8'(model_cnt));
    chk("xfer_cnt_wrap", w_cnt, 2'(model_cnt));
  endtask

  task automatic step();
    item_t pend;
    logic  acc, xfer;
    @(negedge clk);
    check_outputs();
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready;
    pend = model_op(in_data, in_mode, in_mask);
    @(posedge clk);
    if (xfer && q.size() != 0) begin
      void'(q.pop_front());
      model_cnt++;
    end
    if (acc) q.push_back(pend);
    last_acc = acc;
    #1;
  endtask

  task automatic send_expect(input logic [7:0] a, input logic [1:0] m, input logic [7:0] k,
                             input logic [7:0] exp_d, input logic exp_e, input string tag);
    in_valid = 1'b1; in_data = a; in_mode = m; in_mask = k;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && out_valid !== 1'b1; i++) step();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_err"}, out_err, exp_e);
    step();
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk(tag, q.size(), 0);
  endtask

  initial begin
    logic [7:0] words [4];
    logic [1:0] modes [4];
    logic [7:0] held;
    logic       seen;
    int         idx;

    // Reset with garbage inputs
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'($urandom); in_mode = 2'b11;
    in_mask = 8'($urandom); out_ready = 1'b1;
    model_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_xfer_cnt", xfer_cnt, 8'h00);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_wrap_cnt", w_cnt, 2'b00);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // Latency and basic NOT
    in_mode = 2'b00; in_mask = 8'h00; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h00;
    step();
    chk("lat_plus1_valid", out_valid, 1'b0);
    in_data = 8'hFF;
    step();
    chk("lat_plus2_valid", out_valid, 1'b1);
    chk("lat_plus2_data", out_data, 8'hFF);
    in_valid = 1'b0;
    step();
    chk("lat_plus3_valid", out_valid, 1'b1);
    chk("lat_plus3_data", out_data, 8'h00);
    step();
    chk("lat_cnt2", xfer_cnt, 8'd2);
    chk("lat_drained", out_valid, 1'b0);

    // Modes
    send_expect(8'hA5, 2'b01, 8'h0F, 8'hA5, 1'b0, "mode_pass");
    send_expect(8'hA5, 2'b10, 8'h0F, 8'hAA, 1'b0, "mode_mask");
    send_expect(8'hA5, 2'b11, 8'h0F, 8'h5A, 1'b1, "mode_rsvd");
    send_expect(8'hA5, 2'b00, 8'h0F, 8'h5A, 1'b0, "mode_not");
`ifdef NOT_PIPE_PARITY_EN
    send_expect(8'hF8, 2'b00, 8'h00, 8'h07, 1'b0, "par_word");
`endif

    // Backpressure: 4 words, consumer stalled for 5 cycles
    for (int i = 0; i < 4; i++) begin
      words[i] = 8'($urandom);
      modes[i] = 2'($urandom_range(0, 2));
    end
    out_ready = 1'b0; idx = 0; seen = 1'b0; held = '0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = words[idx]; in_mode = modes[idx]; in_mask = 8'($urandom);
      step();
      if (last_acc) idx++;
      if (out_valid === 1'b1) begin
        if (seen) chk("bp_stable", out_data, held);
        held = out_data;
        seen = 1'b1;
      end
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready_low", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && !(idx == 4 && q.size() == 0); c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        in_data = words[idx]; in_mode = modes[idx];
      end
      step();
      if (last_acc) idx++;
    end
    chk("bp_all_accepted", idx, 4);
    chk("bp_all_delivered", q.size(), 0);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      in_mode   = 2'($urandom);
      in_mask   = 8'($urandom);
      step();
    end
    drain("rand_drain");

    // Reset mid-stream with two words in flight
    out_ready = 1'b0; in_mode = 2'b00;
    in_valid = 1'b1; in_data = 8'h3C; step();
    in_data = 8'hC3; step();
    in_valid = 1'b0;
    chk("flush_pre_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_xfer_cnt", xfer_cnt, 8'h00);
    chk("flush_wrap_cnt", w_cnt, 2'b00);
    q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) step();
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_no_words", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
